// File: rtl/vectored_int_ctrl_if.sv
// vectored_int_ctrl_if: CPU/device-side bundle of the vectored interrupt controller
// Signals: irq_in (raw requests), mask_we/mask_wd (mask write), ie_set/ie_clr (global IE),
//          eret (return strobe), pc_next (EPC source), int_take/vec_addr (PC override),
//          epc (return address), int_ack (one-hot ack), status_ie, in_service, active_ch.
// Modports: slave = controller side, master = datapath/device side.
interface vectored_int_ctrl_if #(
  parameter int NUM_CH = 8
);
  logic [NUM_CH-1:0] irq_in;
  logic              mask_we;
  logic [NUM_CH-1:0] mask_wd;
  logic              ie_set;
  logic              ie_clr;
  logic              eret;
  logic [31:0]       pc_next;
  logic              int_take;
  logic [31:0]       vec_addr;
  logic [31:0]       epc;
  logic [NUM_CH-1:0] int_ack;
  logic              status_ie;
  logic              in_service;
  logic [4:0]        active_ch;
  modport slave (
    input  irq_in, mask_we, mask_wd, ie_set, ie_clr, eret, pc_next,
    output int_take, vec_addr, epc, int_ack, status_ie, in_service, active_ch
  );
  modport master (
    output irq_in, mask_we, mask_wd, ie_set, ie_clr, eret, pc_next,
    input  int_take, vec_addr, epc, int_ack, status_ie, in_service, active_ch
  );
endinterface

// File: rtl/vectored_int_ctrl.sv
// vectored_int_ctrl: prioritised edge/level vectored interrupt controller with mask, IE and EPC
// Ports: clk (rising-edge clock), reset (synchronous, active-low),
//        bus (vectored_int_ctrl_if.slave: requests, mask/IE control, eret, pc_next in;
//             int_take, vec_addr, epc, int_ack, status_ie, in_service, active_ch out).
// Channel 0 has highest priority; one interrupt in service at a time, released by eret.
module vectored_int_ctrl #(
  parameter int          NUM_CH    = 8,
  parameter logic [31:0] EDGE_MASK = 32'h0000_00FF,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0200,
  parameter int          VEC_SHIFT = 3
) (
  input logic                 clk,
  input logic                 reset,
  vectored_int_ctrl_if.slave  bus
);
  localparam logic [NUM_CH-1:0] EDGE = EDGE_MASK[NUM_CH-1:0];
  typedef enum logic [1:0] {IDLE, TAKE, SERVICE} state_t;
  state_t            state, state_nx;
  logic [NUM_CH-1:0] prev, pending, pending_nx, mask, req, clr;
  logic [NUM_CH-1:0] int_ack, int_ack_nx;
  logic [4:0]        winner, active_ch, active_ch_nx;
  logic              status_ie, status_ie_nx, int_take, int_take_nx, in_service;
  logic [31:0]       vec_addr, vec_addr_nx, epc, epc_nx;
  always_comb begin
    req = pending & mask;
    winner = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (req[i]) winner = 5'(i);
    clr = '0;
    state_nx = state;
    status_ie_nx = status_ie;
    active_ch_nx = active_ch;
    int_take_nx = 1'b0;
    int_ack_nx = '0;
    vec_addr_nx = vec_addr;
    epc_nx = epc;
    case (state)
      IDLE: begin
        status_ie_nx = bus.ie_clr ? 1'b0 : bus.ie_set ? 1'b1 : status_ie;
        if (status_ie && |req) begin
          state_nx = TAKE;
          active_ch_nx = winner;
          int_take_nx = 1'b1;
          int_ack_nx = NUM_CH'(1) << winner;
          vec_addr_nx = VEC_BASE + (32'(winner) << VEC_SHIFT);
        end
      end
      TAKE: begin
        state_nx = SERVICE;
        epc_nx = bus.pc_next;
        status_ie_nx = 1'b0;
        clr = (NUM_CH'(1) << active_ch) & EDGE;
      end
      SERVICE: begin
        state_nx = bus.eret ? IDLE : SERVICE;
        status_ie_nx = bus.eret ? 1'b1 : status_ie;
        active_ch_nx = bus.eret ? 5'd0 : active_ch;
      end
      default: state_nx = IDLE;
    endcase
    // a fresh rising edge re-arms the channel even while its take-clear is applied
    pending_nx = (EDGE & ((pending & ~clr) | (bus.irq_in & ~prev))) | (~EDGE & bus.irq_in);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      prev <= '0;
      pending <= '0;
      mask <= '0;
      status_ie <= 1'b0;
      active_ch <= '0;
      int_take <= 1'b0;
      int_ack <= '0;
      vec_addr <= '0;
      epc <= '0;
      in_service <= 1'b0;
    end else begin
      state <= state_nx;
      prev <= bus.irq_in;
      pending <= pending_nx;
      mask <= bus.mask_we ? bus.mask_wd : mask;
      status_ie <= status_ie_nx;
      active_ch <= active_ch_nx;
      int_take <= int_take_nx;
      int_ack <= int_ack_nx;
      vec_addr <= vec_addr_nx;
      epc <= epc_nx;
      in_service <= state_nx != IDLE;
    end
  end
  assign bus.int_take = int_take;
  assign bus.vec_addr = vec_addr;
  assign bus.epc = epc;
  assign bus.int_ack = int_ack;
  assign bus.status_ie = status_ie;
  assign bus.in_service = in_service;
  assign bus.active_ch = active_ch;
endmodule

// File: tb/tb_vectored_int_ctrl.sv
// tb_vectored_int_ctrl: directed test-plan steps plus random traffic against a behavioural model
module tb_vectored_int_ctrl;
  localparam logic [7:0] EDGE = 8'h7F;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int errors = 0;
  int m_phase, m_ch;
  bit [7:0] m_pend, m_prev, m_mask;
  bit m_ie;
  bit [31:0] m_epc, m_vec;
  vectored_int_ctrl_if #(.NUM_CH(8)) bus ();
  vectored_int_ctrl #(.NUM_CH(8), .EDGE_MASK(32'h7F), .VEC_BASE(32'h200), .VEC_SHIFT(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  // model: phase 0 idle, 1 handler being entered, 2 handler running
  task automatic model_edge();
    bit [7:0] rise, np;
    int w;
    if (!reset) begin
      m_phase = 0; m_ch = 0; m_pend = 0; m_prev = 0; m_mask = 0;
      m_ie = 0; m_epc = 0; m_vec = 0;
      return;
    end
    rise = bus.irq_in & ~m_prev;
    for (int i = 0; i < 8; i++)
      np[i] = EDGE[i] ? (rise[i] | (m_pend[i] & !(m_phase == 1 && m_ch == i))) : bus.irq_in[i];
    w = -1;
    for (int i = 7; i >= 0; i--) if (m_pend[i] & m_mask[i]) w = i;
    if (m_phase == 0) begin
      if (m_ie && w >= 0) begin
        m_phase = 1; m_ch = w; m_vec = 32'h200 + 32'(w) * 8;
      end
      if (bus.ie_clr) m_ie = 0; else if (bus.ie_set) m_ie = 1;
    end else if (m_phase == 1) begin
      m_phase = 2; m_epc = bus.pc_next; m_ie = 0;
    end else if (bus.eret) begin
      m_phase = 0; m_ie = 1; m_ch = 0;
    end
    m_pend = np;
    m_prev = bus.irq_in;
    if (bus.mask_we) m_mask = bus.mask_wd;
  endtask
  task automatic check_all();
    chk("int_take", bus.int_take, m_phase == 1);
    chk("vec_addr", bus.vec_addr, m_vec);
    chk("epc", bus.epc, m_epc);
    chk("int_ack", bus.int_ack, m_phase == 1 ? 32'(8'd1 << m_ch) : 0);
    chk("status_ie", bus.status_ie, m_ie);
    chk("in_service", bus.in_service, m_phase != 0);
    chk("active_ch", bus.active_ch, m_ch);
  endtask
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic do_eret();
    bus.eret = 1; tick(); bus.eret = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 10 && m_phase != 0; i++) begin
      if (m_phase == 2) do_eret(); else tick();
    end
    chk("drain_idle", bus.in_service, 0);
  endtask
  initial begin
    bus.irq_in = 8'hFF; bus.mask_we = 0; bus.mask_wd = 0; bus.ie_set = 0; bus.ie_clr = 0;
    bus.eret = 0; bus.pc_next = 0;
    // reset with all requests high
    tick(); tick();
    chk("rst_take", bus.int_take, 0);
    chk("rst_epc", bus.epc, 0);
    reset = 1; bus.irq_in = 0;
    tick();
    // single edge on ch3
    bus.mask_we = 1; bus.mask_wd = 8'hFF; bus.ie_set = 1; bus.pc_next = 32'h40;
    tick();
    bus.mask_we = 0; bus.ie_set = 0;
    tick(); tick();
    chk("t1_no_pending", bus.int_take, 0);
    bus.irq_in = 8'h08; tick();
    bus.irq_in = 0; tick();
    chk("t2_take", bus.int_take, 1);
    chk("t2_vec", bus.vec_addr, 32'h218);
    chk("t2_ack", bus.int_ack, 8'h08);
    chk("t2_ch", bus.active_ch, 3);
    tick();
    chk("t2_epc", bus.epc, 32'h40);
    chk("t2_ie", bus.status_ie, 0);
    do_eret();
    // priority: ch2 before ch5
    bus.irq_in = 8'h24; tick();
    bus.irq_in = 0; tick();
    chk("t3_vec2", bus.vec_addr, 32'h210);
    tick(); do_eret(); tick();
    chk("t3_take5", bus.int_take, 1);
    chk("t3_vec5", bus.vec_addr, 32'h228);
    tick(); do_eret();
    // no nesting, return and immediate re-take
    bus.irq_in = 8'h02; tick();
    bus.irq_in = 0; tick(); tick();
    bus.irq_in = 8'h01; tick();
    bus.irq_in = 0; tick(); tick();
    chk("t4_no_nest", bus.int_take, 0);
    bus.pc_next = 32'h123; do_eret();
    chk("t4_ie", bus.status_ie, 1);
    tick();
    chk("t4_take0", bus.int_take, 1);
    bus.pc_next = 32'h5A0; tick();
    chk("t4_epc", bus.epc, 32'h5A0);
    do_eret();
    // masked channel keeps its pending bit
    bus.mask_we = 1; bus.mask_wd = 8'hFE; tick();
    bus.mask_we = 0; bus.irq_in = 8'h01; tick();
    bus.irq_in = 0; tick(); tick();
    chk("t5_masked", bus.int_take, 0);
    bus.mask_we = 1; bus.mask_wd = 8'hFF; tick();
    bus.mask_we = 0; tick();
    chk("t5_take", bus.int_take, 1);
    chk("t5_vec", bus.vec_addr, 32'h200);
    tick(); do_eret();
    // level ch7 re-taken after eret
    bus.irq_in = 8'h80; tick(); tick();
    chk("t6_take7", bus.active_ch, 7);
    tick(); do_eret(); tick();
    chk("t6_retake7", bus.int_take, 1);
    bus.irq_in = 0;
    drain();
    // edge ch6 held high taken once
    tick(); tick();
    bus.irq_in = 8'h40; tick(); tick();
    chk("t6_take6", bus.vec_addr, 32'h230);
    tick(); do_eret(); tick(); tick();
    chk("t6_once6", bus.int_take, 0);
    bus.irq_in = 0; tick();
    bus.ie_set = 1; bus.ie_clr = 1; tick();
    chk("t6_ie_clr_wins", bus.status_ie, 0);
    bus.ie_set = 0; bus.ie_clr = 0;
    // random traffic
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) != 0);
      bus.irq_in = 8'($urandom) & 8'($urandom) & 8'($urandom);
      bus.mask_we = ($urandom_range(0, 9) == 0);
      bus.mask_wd = 8'($urandom) | 8'($urandom);
      bus.ie_set = ($urandom_range(0, 3) == 0);
      bus.ie_clr = ($urandom_range(0, 15) == 0);
      bus.eret = ($urandom_range(0, 4) == 0);
      bus.pc_next = $urandom;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/vectored_int_ctrl.md
Name: vectored_int_ctrl

Overview:
Parametrised vectored interrupt controller for the single-cycle MIPS core. It replaces the fixed four-source done/interrupt-encoder arrangement with the following:
- NUM_CH prioritised sources, each configurable as edge or level triggered.
- A per-channel mask register and a global interrupt-enable (IE) status bit.
- An EPC capture register and a one-hot per-channel acknowledge.
It sits beside the datapath. It drives the PC-mux override (int_take / vec_addr) and supplies epc for the return path.

Parameters:
NUM_CH, 8, number of interrupt sources (1..32); channel 0 has highest priority.
EDGE_MASK, 8'hFF, bit i = 1: channel i edge-triggered (rising); 0: level-triggered.
VEC_BASE, 32'h0000_0200, byte address of channel 0 handler.
VEC_SHIFT, 3, log2 of the handler stride in bytes (8 bytes = 2 instructions).

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
irq_in  in  NUM_CH  raw interrupt requests, already synchronous to clk
mask_we  in  1  write strobe for the mask register
mask_wd  in  NUM_CH  new mask value (1 = channel enabled)
ie_set  in  1  set global IE (CPU executes interrupt-enable)
ie_clr  in  1  clear global IE
eret  in  1  return-from-interrupt strobe from decoder
pc_next  in  32  next-PC value from the datapath, captured as EPC
int_take  out  1  one-cycle pulse; PC mux selects vec_addr
vec_addr  out  32  handler address, valid while int_take = 1
epc  out  32  saved return address, selected by PC mux on eret
int_ack  out  NUM_CH  one-hot acknowledge pulse to the serviced device, concurrent with int_take
status_ie  out  1  global IE bit
in_service  out  1  high from int_take through the eret cycle
active_ch  out  5  index of the channel being serviced (0 when idle)

Behaviour:
- Reset (reset = 0 at a clock edge) zeroes the following registers:
  - all outputs, including epc
  - mask register and status_ie
  - pending register and edge-history register
  - state returns to IDLE
- Reset in SERVICE abandons service; no eret is needed afterwards.
- Edge detection:
  - prev <= irq_in every cycle.
  - Edge channel i: pending[i] is set when irq_in[i] & ~prev[i]. It stays set until that channel is taken.
  - Level channel i: pending[i] = irq_in[i], registered each cycle, never cleared by take.
  - If a set event and a take-clear hit the same edge channel in the same cycle, set wins (the new edge is not lost).
- Request: req = pending & mask. winner = lowest set index of req.
- State machine (registered):
  - IDLE: if status_ie & |req, go to TAKE. Latch winner into active_ch.
  - TAKE (exactly 1 cycle), with registered outputs:
    - int_take = 1 and int_ack[active_ch] = 1
    - vec_addr = VEC_BASE + (active_ch << VEC_SHIFT), 32-bit modulo
    - in_service = 1
  - At the end of TAKE:
    - epc <= pc_next
    - status_ie <= 0
    - pending[active_ch] cleared if the channel is edge-type
    - go to SERVICE
  - SERVICE: wait for eret. in_service = 1. New requests accumulate in pending but are not taken (no nesting).
  - On eret: status_ie <= 1, active_ch <= 0, go to IDLE. An interrupt may be taken on the very next cycle.
  - An eret strobe outside SERVICE is ignored.
- Latency:
  - Edge-channel irq high at edge k sets pending at k.
  - int_take is high in the cycle after edge k+1.
  - Total: 2 cycles from irq assertion to int_take, provided IE and the mask are already 1.
- IE control:
  - ie_set and ie_clr act only in IDLE.
  - When both are asserted, ie_clr wins.
  - In TAKE/SERVICE, IE is owned by the state machine.
- Mask writes are accepted in any state and take effect at the next edge. Masking a channel does not clear its pending bit.
- vec_addr holds its last value when int_take = 0. int_ack is all zeros outside TAKE.

Test Plan:
1. Reset: reset = 0 for 2 cycles with irq_in = 8'hFF -> int_take = 0, status_ie = 0, epc = 0, int_ack = 0 throughout; pending is empty after release.
2. Single edge: mask = FF, ie_set, pc_next = 0x40, pulse irq_in[3] for 1 cycle -> 2 cycles later int_take = 1, vec_addr = 0x218, int_ack = 8'h08, active_ch = 3; next cycle epc = 0x40, status_ie = 0.
3. Priority: irq_in[5] and irq_in[2] rise together -> ch 2 is taken (vec 0x210); after eret, ch 5 is taken on the following cycle (vec 0x228).
4. No nesting / return: during SERVICE, raise irq_in[0] -> no int_take; eret -> status_ie = 1; ch 0 is taken 1 cycle later, with epc = the pc_next value present in that TAKE cycle.
5. Mask: mask = 8'hFE, pulse irq_in[0] -> no take; write mask = FF -> ch 0 is taken one cycle later (pending was retained).
6. Level vs edge: with EDGE_MASK = 8'h7F, hold irq_in[7] high through eret -> ch 7 is re-taken after eret; hold irq_in[6] high -> taken once only. Also assert ie_set and ie_clr together in IDLE -> status_ie = 0.
